// File: rtl/alu_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_sequencer_if
// Brief    : Request/response valid-ready channels of the ALU sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface alu_sequencer_if;
    logic       req_valid;
    logic       req_ready;
    logic [2:0] req_op;
    logic [3:0] req_a;
    logic [3:0] req_b;
    logic       req_use_acc;

    logic       rsp_valid;
    logic       rsp_ready;
    logic [3:0] rsp_result;
    logic       rsp_carry;
    logic       rsp_zero;

    modport master (
        output req_valid, req_op, req_a, req_b, req_use_acc, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_carry, rsp_zero
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, req_use_acc, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_carry, rsp_zero
    );
endinterface
`default_nettype wire

// File: rtl/alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_sequencer
// Brief    : Drives a 4-bit combinational ALU for a settle window, captures its
//            result into a response channel and a chaining accumulator.
// Revision : 1.0 - initial release
// ============================================================================
module alu_sequencer #(
    parameter int SETTLE_CYCLES = 1
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    alu_sequencer_if.slave   bus,
    input  wire logic        acc_clr,
    output logic       [3:0] alu_a,
    output logic       [3:0] alu_b,
    output logic             alu_s0,
    output logic             alu_s1,
    output logic             alu_s2,
    input  wire logic        alu_outp1,
    input  wire logic        alu_outp2,
    input  wire logic        alu_outp3,
    input  wire logic        alu_outp4,
    input  wire logic        alu_carr,
    output logic       [3:0] acc_out,
    output logic             busy
);

    localparam logic [3:0] c_settle_load = 4'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic       w_accept;
    logic       w_capture;
    logic [3:0] w_result;

    logic [3:0] r_a;
    logic [3:0] r_b;
    logic [2:0] r_op;
    logic [3:0] r_cnt;
    logic [3:0] r_result;
    logic       r_carry;
    logic       r_zero;
    logic [3:0] r_acc;

    assign w_result = {alu_outp1, alu_outp2, alu_outp3, alu_outp4};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                if (r_cnt == 4'd0) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Operand/opcode registers feed the ALU directly and keep their value
    // outside DRIVE so the ALU inputs never glitch between operations.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a      <= 4'd0;
            r_b      <= 4'd0;
            r_op     <= 3'd0;
            r_cnt    <= 4'd0;
            r_result <= 4'd0;
            r_carry  <= 1'b0;
            r_zero   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_a   <= bus.req_use_acc ? r_acc : bus.req_a;
                r_b   <= bus.req_b;
                r_op  <= bus.req_op;
                r_cnt <= c_settle_load;
            end else if (r_state == ST_DRIVE && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_capture) begin
                r_result <= w_result;
                // Carry mux is undriven for logic/shift ops, so mask it.
                r_carry  <= alu_carr & ~r_op[2];
                r_zero   <= (w_result == 4'd0);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= 4'd0;
        end else if (acc_clr) begin
            r_acc <= 4'd0;
        end else if (w_capture) begin
            r_acc <= w_result;
        end
    end

    assign bus.req_ready  = (r_state == ST_IDLE);
    assign bus.rsp_valid  = (r_state == ST_RESP);
    assign bus.rsp_result = r_result;
    assign bus.rsp_carry  = r_carry;
    assign bus.rsp_zero   = r_zero;

    assign alu_a   = r_a;
    assign alu_b   = r_b;
    assign alu_s0  = r_op[2];
    assign alu_s1  = r_op[1];
    assign alu_s2  = r_op[0];
    assign acc_out = r_acc;
    assign busy    = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_sequencer
// Brief    : Directed scoreboard bench for alu_sequencer (settle 1 and 3).
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_sequencer;

    typedef struct packed {
        logic [3:0] res;
        logic       c;
        logic       z;
        logic [3:0] acc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sel = 1'b0;
    logic       req_valid = 1'b0;
    logic [2:0] req_op = 3'd0;
    logic [3:0] req_a = 4'd0;
    logic [3:0] req_b = 4'd0;
    logic       req_use_acc = 1'b0;
    logic       rsp_ready = 1'b0;
    logic       acc_clr = 1'b0;

    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    // ALU stub; carry for logic/shift ops is driven 1 to expose masking.
    function automatic logic [4:0] alu_stub(input logic [3:0] a, input logic [3:0] b,
                                            input logic s0, input logic s1, input logic s2);
        case ({s0, s1, s2})
            3'd0:    return {1'b0, a} + {1'b0, b};
            3'd1:    return {1'b0, a} + {1'b0, ~b} + 5'd1;
            3'd2:    return {1'b0, a} + 5'd1;
            3'd3:    return {1'b0, a} + 5'h0f;
            3'd4:    return {1'b1, a & b};
            3'd5:    return {1'b1, a | b};
            3'd6:    return {1'b1, a ^ b};
            default: return {1'b1, a[3], a[3:1]};
        endcase
    endfunction

    alu_sequencer_if bus1();
    alu_sequencer_if bus3();

    assign bus1.req_valid   = req_valid & ~sel;
    assign bus1.req_op      = req_op;
    assign bus1.req_a       = req_a;
    assign bus1.req_b       = req_b;
    assign bus1.req_use_acc = req_use_acc;
    assign bus1.rsp_ready   = rsp_ready;
    assign bus3.req_valid   = req_valid & sel;
    assign bus3.req_op      = req_op;
    assign bus3.req_a       = req_a;
    assign bus3.req_b       = req_b;
    assign bus3.req_use_acc = req_use_acc;
    assign bus3.rsp_ready   = rsp_ready;

    logic [3:0] a1, b1, acc1, a3, b3, acc3;
    logic       s01, s11, s21, busy1, s03, s13, s23, busy3;
    logic [4:0] w_alu1, w_alu3;

    assign w_alu1 = alu_stub(a1, b1, s01, s11, s21);
    assign w_alu3 = alu_stub(a3, b3, s03, s13, s23);

    alu_sequencer #(.SETTLE_CYCLES(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1), .acc_clr(acc_clr),
        .alu_a(a1), .alu_b(b1), .alu_s0(s01), .alu_s1(s11), .alu_s2(s21),
        .alu_outp1(w_alu1[3]), .alu_outp2(w_alu1[2]), .alu_outp3(w_alu1[1]),
        .alu_outp4(w_alu1[0]), .alu_carr(w_alu1[4]),
        .acc_out(acc1), .busy(busy1)
    );

    alu_sequencer #(.SETTLE_CYCLES(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .bus(bus3), .acc_clr(acc_clr),
        .alu_a(a3), .alu_b(b3), .alu_s0(s03), .alu_s1(s13), .alu_s2(s23),
        .alu_outp1(w_alu3[3]), .alu_outp2(w_alu3[2]), .alu_outp3(w_alu3[1]),
        .alu_outp4(w_alu3[0]), .alu_carr(w_alu3[4]),
        .acc_out(acc3), .busy(busy3)
    );

    logic       w_req_ready, w_rsp_valid, w_rsp_carry, w_rsp_zero, w_busy;
    logic [3:0] w_rsp_result, w_acc, w_alu_a, w_alu_b;
    logic [2:0] w_sel_lines;

    assign w_req_ready  = sel ? bus3.req_ready  : bus1.req_ready;
    assign w_rsp_valid  = sel ? bus3.rsp_valid  : bus1.rsp_valid;
    assign w_rsp_result = sel ? bus3.rsp_result : bus1.rsp_result;
    assign w_rsp_carry  = sel ? bus3.rsp_carry  : bus1.rsp_carry;
    assign w_rsp_zero   = sel ? bus3.rsp_zero   : bus1.rsp_zero;
    assign w_busy       = sel ? busy3 : busy1;
    assign w_acc        = sel ? acc3  : acc1;
    assign w_alu_a      = sel ? a3    : a1;
    assign w_alu_b      = sel ? b3    : b1;
    assign w_sel_lines  = sel ? {s03, s13, s23} : {s01, s11, s21};

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_rsp(output int n);
        n = 0;
        while (!w_rsp_valid && n < 40) begin
            check("req_ready_low_busy", 8'(w_req_ready), 8'd0);
            @(posedge clk); #1;
            acc_clr = 1'b0;
            n++;
        end
    endtask

    task automatic pop_compare(input string tag);
        exp_t e;
        check({tag, "_sb_nonempty"}, 8'(sb.size() != 0), 8'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check({tag, "_result"}, 8'(w_rsp_result), 8'(e.res));
            check({tag, "_carry"},  8'(w_rsp_carry),  8'(e.c));
            check({tag, "_zero"},   8'(w_rsp_zero),   8'(e.z));
            check({tag, "_acc"},    8'(w_acc),        8'(e.acc));
        end
    endtask

    task automatic handshake(input string tag);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check({tag, "_rsp_valid_drop"}, 8'(w_rsp_valid), 8'd0);
        check({tag, "_req_ready_back"}, 8'(w_req_ready), 8'd1);
    endtask

    task automatic send(input string tag, input logic [2:0] op, input logic [3:0] a,
                        input logic [3:0] b, input logic ua, input logic [3:0] ea,
                        input logic [3:0] er, input logic ec, input logic [3:0] eacc,
                        input logic clr, input int settle);
        int n;
        req_op = op; req_a = a; req_b = b; req_use_acc = ua; req_valid = 1'b1;
        check({tag, "_req_ready"}, 8'(w_req_ready), 8'd1);
        sb.push_back({er, ec, (er == 4'd0), eacc});
        @(posedge clk); #1;
        req_valid = 1'b0;
        acc_clr   = clr;
        check({tag, "_alu_a"},   8'(w_alu_a), 8'(ea));
        check({tag, "_alu_b"},   8'(w_alu_b), 8'(b));
        check({tag, "_alu_sel"}, 8'(w_sel_lines), 8'(op));
        wait_rsp(n);
        check({tag, "_latency"}, 8'(n), 8'(settle));
        pop_compare(tag);
        handshake(tag);
    endtask

    initial begin
        int n;
        #12;
        check("rst_req_ready", 8'(w_req_ready), 8'd1);
        check("rst_rsp_valid", 8'(w_rsp_valid), 8'd0);
        check("rst_busy",      8'(w_busy), 8'd0);
        check("rst_acc",       8'(w_acc), 8'd0);
        check("rst_alu",       {w_alu_a, w_alu_b}, 8'd0);
        check("rst_sel_lines", 8'(w_sel_lines), 8'd0);
        check("rst_rsp",       {2'b00, w_rsp_result, w_rsp_carry, w_rsp_zero}, 8'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        send("add",  3'b000, 4'b1011, 4'b0010, 1'b0, 4'b1011, 4'b1101, 1'b0, 4'b1101, 1'b0, 1);
        send("sub",  3'b001, 4'b1011, 4'b0010, 1'b0, 4'b1011, 4'b1001, 1'b1, 4'b1001, 1'b0, 1);
        send("dec",  3'b011, 4'b1011, 4'b0010, 1'b0, 4'b1011, 4'b1010, 1'b1, 4'b1010, 1'b0, 1);
        send("inc",  3'b010, 4'b1111, 4'b0010, 1'b0, 4'b1111, 4'b0000, 1'b1, 4'b0000, 1'b0, 1);
        send("asr",  3'b111, 4'b1011, 4'b0010, 1'b0, 4'b1011, 4'b1101, 1'b0, 4'b1101, 1'b0, 1);
        send("xor",  3'b110, 4'b1011, 4'b0010, 1'b0, 4'b1011, 4'b1001, 1'b0, 4'b1001, 1'b0, 1);

        // Reset pulse while DRIVE is active; no response may follow.
        req_op = 3'b000; req_a = 4'b0001; req_b = 4'b0001; req_use_acc = 1'b0;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("rstmid_busy_before", 8'(w_busy), 8'd1);
        rst_n = 1'b0;
        #2;
        check("rstmid_rsp_valid", 8'(w_rsp_valid), 8'd0);
        check("rstmid_acc",       8'(w_acc), 8'd0);
        check("rstmid_req_ready", 8'(w_req_ready), 8'd1);
        check("rstmid_busy",      8'(w_busy), 8'd0);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("rstmid_no_rsp", 8'(w_rsp_valid), 8'd0);
        end

        send("chain0", 3'b000, 4'b0011, 4'b0001, 1'b0, 4'b0011, 4'b0100, 1'b0, 4'b0100, 1'b0, 1);
        send("chain1", 3'b000, 4'b1111, 4'b0010, 1'b1, 4'b0100, 4'b0110, 1'b0, 4'b0110, 1'b0, 1);
        send("clrcap", 3'b101, 4'b1111, 4'b0000, 1'b1, 4'b0110, 4'b0110, 1'b0, 4'b0000, 1'b1, 1);

        // Backpressure on the three-cycle settle instance.
        sel = 1'b1;
        @(posedge clk); #1;
        req_op = 3'b000; req_a = 4'b0101; req_b = 4'b0011; req_use_acc = 1'b0;
        req_valid = 1'b1;
        sb.push_back({4'b1000, 1'b0, 1'b0, 4'b1000});
        @(posedge clk); #1;
        check("bp_busy", 8'(w_busy), 8'd1);
        req_a = 4'b1111; req_b = 4'b0001; req_use_acc = 1'b1;
        sb.push_back({4'b1001, 1'b0, 1'b0, 4'b1001});
        wait_rsp(n);
        check("bp_latency", 8'(n), 8'd3);
        for (int i = 0; i < 5; i++) begin
            check("bp_hold_valid",     8'(w_rsp_valid), 8'd1);
            check("bp_hold_result",    8'(w_rsp_result), 8'b1000);
            check("bp_hold_req_ready", 8'(w_req_ready), 8'd0);
            @(posedge clk); #1;
        end
        pop_compare("bp_first");
        handshake("bp_first");
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("bp_second_accepted", 8'(w_busy), 8'd1);
        check("bp_second_alu_a",    8'(w_alu_a), 8'b1000);
        wait_rsp(n);
        check("bp_second_latency", 8'(n), 8'd3);
        pop_compare("bp_second");
        handshake("bp_second");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
